// File: rtl/player_kinematics.sv
// -----------------------------------------------------------------------------
// player_kinematics
//
// Turns the limited mouse/jump position into the blob's final on-screen
// coordinates. The x coordinate is clamped to the player's half-court and is
// rate-limited to MAX_STEP pixels per physics tick. The y coordinate is
// clamped so the blob never sinks below the ground line. Signed per-tick
// velocities are produced for the ball-bounce physics. A small state machine
// tracks ground/air state and emits one-tick jump and land pulses.
//
// Every output is registered. Inputs sampled on one clk_div edge are visible
// after the next edge.
//
// Ports
//   clk_div     in   1   physics tick clock, all state changes on posedge
//   rst         in   1   synchronous, active-high reset
//   xpos_in     in   12  unsigned target x from the limiter
//   ypos_in     in   12  unsigned y from the jump generator
//   x_player    out  12  clamped, rate-limited x
//   y_player    out  12  y, never below GROUND_Y
//   vx          out  8   signed x velocity in px/tick, positive is rightwards
//   vy          out  8   signed y velocity in px/tick, positive is upwards
//   airborne    out  1   1 while the blob is above the ground
//   jump_pulse  out  1   one tick on a ground-to-air transition
//   land_pulse  out  1   one tick on an air-to-ground transition
//   valid       out  1   outputs meaningful, low only in the tick after reset
// -----------------------------------------------------------------------------
module player_kinematics #(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 500,
    parameter int X_START  = 250,
    parameter int GROUND_Y = 679,
    parameter int MAX_STEP = 24
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    output logic [11:0] x_player,
    output logic [11:0] y_player,
    output logic [7:0]  vx,
    output logic [7:0]  vy,
    output logic        airborne,
    output logic        jump_pulse,
    output logic        land_pulse,
    output logic        valid
);

    // Parameters resized once so every comparison below is width-matched.
    localparam logic [11:0]        X_MIN_C    = 12'(X_MIN);
    localparam logic [11:0]        X_MAX_C    = 12'(X_MAX);
    localparam logic [11:0]        X_START_C  = 12'(X_START);
    localparam logic [11:0]        GROUND_C   = 12'(GROUND_Y);
    localparam logic signed [12:0] STEP_POS_C = 13'(MAX_STEP);
    localparam logic signed [12:0] STEP_NEG_C = -13'(MAX_STEP);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_GROUND = 2'd1,
        ST_AIR    = 2'd2
    } state_t;

    // Saturate a 13-bit signed difference into the 8-bit signed velocity range.
    function automatic logic [7:0] sat8(input logic signed [12:0] val);
        logic [7:0] res;
        if (val > 13'sd127) begin
            res = 8'h7F;
        end else if (val < -13'sd128) begin
            res = 8'h80;
        end else begin
            res = val[7:0];
        end
        return res;
    endfunction

    // Registered state and outputs
    state_t      state_r;
    logic [11:0] x_player_r;
    logic [11:0] y_player_r;
    logic [7:0]  vx_r;
    logic [7:0]  vy_r;
    logic        airborne_r;
    logic        jump_pulse_r;
    logic        land_pulse_r;
    logic        valid_r;

    // Combinational datapath
    logic [11:0]        tgt_s;
    logic signed [12:0] dx_s;
    logic signed [12:0] step_s;
    logic [11:0]        x_step_s;
    logic [11:0]        yc_s;
    logic signed [12:0] dy_s;
    logic [7:0]         vy_sat_s;

    // Next-state values
    state_t      state_nxt_s;
    logic [11:0] x_nxt_s;
    logic [11:0] y_nxt_s;
    logic [7:0]  vx_nxt_s;
    logic [7:0]  vy_nxt_s;
    logic        airborne_nxt_s;
    logic        jump_nxt_s;
    logic        land_nxt_s;
    logic        valid_nxt_s;

    // Clamp the x target into the half-court. The lower bound is compared
    // signed with a zero-extended input so a zero X_MIN is not a constant
    // unsigned comparison, and large inputs clamp rather than wrap.
    always_comb begin
        tgt_s = xpos_in;
        if ($signed({1'b0, xpos_in}) < $signed({1'b0, X_MIN_C})) begin
            tgt_s = X_MIN_C;
        end else if (xpos_in > X_MAX_C) begin
            tgt_s = X_MAX_C;
        end else begin
            tgt_s = xpos_in;
        end
    end

    // Rate limiter: the applied step is the signed distance to the target,
    // limited to +/-MAX_STEP. The 12-bit add is exact because the result
    // always lies between the current x and the clamped target.
    always_comb begin
        dx_s   = $signed({1'b0, tgt_s}) - $signed({1'b0, x_player_r});
        step_s = dx_s;
        if (dx_s > STEP_POS_C) begin
            step_s = STEP_POS_C;
        end else if (dx_s < STEP_NEG_C) begin
            step_s = STEP_NEG_C;
        end else begin
            step_s = dx_s;
        end
        x_step_s = x_player_r + step_s[11:0];
    end

    // Y path: anything at or below the ground line is treated as ground.
    // Screen y grows downwards, so old minus new gives an upward-positive
    // velocity.
    always_comb begin
        yc_s = ypos_in;
        if (ypos_in > GROUND_C) begin
            yc_s = GROUND_C;
        end else begin
            yc_s = ypos_in;
        end
        dy_s     = $signed({1'b0, y_player_r}) - $signed({1'b0, yc_s});
        vy_sat_s = sat8(dy_s);
    end

    // Ground/air FSM and selection of next output values.
    always_comb begin
        state_nxt_s    = state_r;
        x_nxt_s        = x_step_s;
        y_nxt_s        = yc_s;
        vx_nxt_s       = step_s[7:0];
        vy_nxt_s       = vy_sat_s;
        airborne_nxt_s = 1'b0;
        jump_nxt_s     = 1'b0;
        land_nxt_s     = 1'b0;
        valid_nxt_s    = 1'b1;

        case (state_r)
            ST_INIT: begin
                // First tick after reset: snap to the clamped inputs with
                // no rate limit and no motion, and raise no events.
                x_nxt_s  = tgt_s;
                vx_nxt_s = 8'd0;
                vy_nxt_s = 8'd0;
                if (yc_s < GROUND_C) begin
                    state_nxt_s    = ST_AIR;
                    airborne_nxt_s = 1'b1;
                end else begin
                    state_nxt_s    = ST_GROUND;
                    airborne_nxt_s = 1'b0;
                end
            end
            ST_GROUND: begin
                if (yc_s < GROUND_C) begin
                    state_nxt_s    = ST_AIR;
                    airborne_nxt_s = 1'b1;
                    jump_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s    = ST_GROUND;
                    airborne_nxt_s = 1'b0;
                end
            end
            ST_AIR: begin
                if (yc_s == GROUND_C) begin
                    state_nxt_s    = ST_GROUND;
                    airborne_nxt_s = 1'b0;
                    land_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s    = ST_AIR;
                    airborne_nxt_s = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: fall back to INIT, which reloads
                // the position on the following tick.
                state_nxt_s = ST_INIT;
                x_nxt_s     = x_player_r;
                y_nxt_s     = y_player_r;
                vx_nxt_s    = 8'd0;
                vy_nxt_s    = 8'd0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset. A reset in the air
    // simply drops back to the reset values, so no land pulse is produced.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_r      <= ST_INIT;
            x_player_r   <= X_START_C;
            y_player_r   <= GROUND_C;
            vx_r         <= 8'd0;
            vy_r         <= 8'd0;
            airborne_r   <= 1'b0;
            jump_pulse_r <= 1'b0;
            land_pulse_r <= 1'b0;
            valid_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            x_player_r   <= x_nxt_s;
            y_player_r   <= y_nxt_s;
            vx_r         <= vx_nxt_s;
            vy_r         <= vy_nxt_s;
            airborne_r   <= airborne_nxt_s;
            jump_pulse_r <= jump_nxt_s;
            land_pulse_r <= land_nxt_s;
            valid_r      <= valid_nxt_s;
        end
    end

    assign x_player   = x_player_r;
    assign y_player   = y_player_r;
    assign vx         = vx_r;
    assign vy         = vy_r;
    assign airborne   = airborne_r;
    assign jump_pulse = jump_pulse_r;
    assign land_pulse = land_pulse_r;
    assign valid      = valid_r;

endmodule

// File: tb/tb_player_kinematics.sv
// -----------------------------------------------------------------------------
// tb_player_kinematics
//
// Directed vectors with hand-computed expected outputs. The stimulus process
// drives one vector per tick and pushes the expected registered outputs into
// a scoreboard queue. A separate monitor pops one entry each falling edge
// and compares it with what the DUT presents.
// -----------------------------------------------------------------------------
module tb_player_kinematics;

    logic        clk_div = 1'b0;
    logic        rst     = 1'b1;
    logic [11:0] xpos_in = 12'd100;
    logic [11:0] ypos_in = 12'd679;
    logic [11:0] x_player;
    logic [11:0] y_player;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic        airborne;
    logic        jump_pulse;
    logic        land_pulse;
    logic        valid;

    player_kinematics dut (
        .clk_div    (clk_div),
        .rst        (rst),
        .xpos_in    (xpos_in),
        .ypos_in    (ypos_in),
        .x_player   (x_player),
        .y_player   (y_player),
        .vx         (vx),
        .vy         (vy),
        .airborne   (airborne),
        .jump_pulse (jump_pulse),
        .land_pulse (land_pulse),
        .valid      (valid)
    );

    always #5 clk_div = ~clk_div;

    // Expected output word: x, y, vx, vy, airborne, jump, land, valid
    typedef logic [43:0] exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_push = 0;

    // Monitor: compare the DUT outputs with the oldest expectation.
    always @(negedge clk_div) begin
        exp_t e;
        exp_t a;
        int   id;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = {x_player, y_player, vx, vy, airborne, jump_pulse, land_pulse, valid};
            n_vec = n_vec + 1;
            if (a !== e) begin
                n_miss = n_miss + 1;
                $display("FAIL vec%0d: got x=%0d y=%0d vx=%0d vy=%0d ajlv=%b, expected x=%0d y=%0d vx=%0d vy=%0d ajlv=%b",
                         id, a[43:32], a[31:20], $signed(a[19:12]), $signed(a[11:4]), a[3:0],
                         e[43:32], e[31:20], $signed(e[19:12]), $signed(e[11:4]), e[3:0]);
            end
        end
    end

    // Drive one tick of stimulus and queue the outputs expected after it.
    task automatic apply(input logic r, input int x, input int y,
                         input int ex, input int ey, input int evx, input int evy,
                         input logic ea, input logic ej, input logic el, input logic ev);
        exp_t e;
        @(negedge clk_div);
        #1;
        rst     = r;
        xpos_in = 12'(x);
        ypos_in = 12'(y);
        e = {12'(ex), 12'(ey), 8'(evx), 8'(evy), ea, ej, el, ev};
        exp_q.push_back(e);
        id_q.push_back(n_push);
        n_push = n_push + 1;
    endtask

    initial begin
        // Reset values
        apply(1'b1, 100, 679, 250, 679, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // INIT loads clamped inputs directly
        apply(1'b0, 100, 679, 100, 679, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Rate-limited run from 100 to 400: twelve full steps, then 12 left
        for (int i = 1; i <= 12; i++) begin
            apply(1'b0, 400, 679, 100 + 24 * i, 679, 24, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        apply(1'b0, 400, 679, 400, 679, 12, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 400, 679, 400, 679, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Move to 490: 424, 448, 472, then 490 with vx=18
        apply(1'b0, 490, 679, 424, 679, 24, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 490, 679, 448, 679, 24, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 490, 679, 472, 679, 24, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 490, 679, 490, 679, 18, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Upper clamp: 900 and 4095 both clamp to 500
        apply(1'b0, 900, 679, 500, 679, 10, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 4095, 679, 500, 679, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Leftward limited step
        apply(1'b0, 0, 679, 476, 679, -24, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Jump arc 679 -> 670 -> 650 -> 679 while x holds at 476
        apply(1'b0, 476, 670, 476, 670, 0, 9, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 476, 650, 476, 650, 0, 20, 1'b1, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 476, 679, 476, 679, 0, -29, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(1'b0, 476, 679, 476, 679, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Below-ground input while grounded
        apply(1'b0, 476, 700, 476, 679, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Single-tick excursion gives jump then land on consecutive ticks,
        // with horizontal motion in the air
        apply(1'b0, 500, 660, 500, 660, 24, 19, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 500, 679, 500, 679, 0, -19, 1'b0, 1'b0, 1'b1, 1'b1);
        // Jump to 400: vy saturates at +127
        apply(1'b0, 500, 400, 500, 400, 0, 127, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 500, 400, 500, 400, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        // Reset mid-air: reset values, no land pulse
        apply(1'b1, 300, 679, 250, 679, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // INIT reloads position while airborne
        apply(1'b0, 300, 400, 300, 400, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 300, 400, 300, 400, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        // Landing from 400: vy saturates at -128
        apply(1'b0, 300, 679, 300, 679, 0, -128, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(1'b0, 300, 679, 300, 679, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Let the monitor drain the queue, bounded by a cycle budget
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() > 0) begin
                @(negedge clk_div);
            end
        end
        #2;
        if (exp_q.size() != 0 || n_vec != n_push) begin
            n_miss = n_miss + 1;
            $display("FAIL drain: checked %0d of %0d expected vectors", n_vec, n_push);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
